// File: rtl/counter_pkg.sv
// Purpose : shared types and elaboration helpers for the modulo-N counter.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
package counter_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

  // Ceiling log2, usable in constant expressions; clog2(1) = 0.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/dff_vec.sv
// Purpose : WIDTH-bit register bank with asynchronous active-low reset to 0.
// Latency : d visible on q one clock after the rising edge.
// Backpressure: none; captures d every cycle.
// Ports   : clk, rst_n (async, active-low), d (next value), q (registered value).
module dff_vec #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else        q <= d;
  end

endmodule

// File: rtl/counter_mod.sv
// Purpose : modulo-MODULUS up/down counter with clear, load, wrap/saturate, tc, wrap pulse, sticky err.
// Latency : clear/load/count visible on out one cycle after the sampling edge; tc is combinational.
// Backpressure: none; en gates counting, clr > ld > en > hold.
// Ports   : clk; rst (async, active-low); clr, ld, ld_val, en, up (controls);
//           out (count), tc (terminal count), wrap (one-cycle pulse), err (sticky error).
module counter_mod
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 10,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             wrap,
  output logic             err
);

  if (MODULUS < 2 || clog2(MODULUS) > WIDTH) begin : g_bad_params
    $error("counter_mod: need MODULUS >= 2 and 2**WIDTH >= MODULUS");
  end

  localparam int             MAX_I = MODULUS - 1;
  localparam logic [WIDTH:0] MAX_V = MAX_I[WIDTH:0];
  localparam logic [WIDTH:0] ONE   = {{WIDTH{1'b0}}, 1'b1};
  localparam mode_e          MODE  = (SATURATE != 0) ? MODE_SAT : MODE_WRAP;

  logic [WIDTH-1:0] out_d, out_q;
  logic             wrap_d, wrap_q;
  logic             err_d, err_q;

  // One bit wider than the state so MODULUS = 2**WIDTH cannot overflow silently.
  logic [WIDTH:0] cnt_ext, ld_ext, inc, dec;
  dir_e           dir;

  assign cnt_ext = {1'b0, out_q};
  assign ld_ext  = {1'b0, ld_val};
  assign inc     = cnt_ext + ONE;
  assign dec     = cnt_ext - ONE;
  assign dir     = dir_e'(up);

  always_comb begin
    out_d  = out_q;
    wrap_d = 1'b0;
    err_d  = err_q;
    if (clr) begin
      out_d = '0;
      err_d = 1'b0;
    end else if (ld) begin
      if (ld_ext <= MAX_V) out_d = ld_val;
      else                 err_d = 1'b1;
      if (cnt_ext > MAX_V) err_d = 1'b1;
    end else if (cnt_ext > MAX_V) begin
      // Upset left the register outside the count range: recover to 0 and flag it.
      out_d = '0;
      err_d = 1'b1;
    end else if (en) begin
      if (dir == DIR_UP) begin
        if (inc > MAX_V) begin
          if (MODE == MODE_WRAP) begin
            out_d  = '0;
            wrap_d = 1'b1;
          end
        end else begin
          out_d = inc[WIDTH-1:0];
        end
      end else begin
        // Borrow out of the extended bit means we were at 0.
        if (dec[WIDTH]) begin
          if (MODE == MODE_WRAP) begin
            out_d  = MAX_V[WIDTH-1:0];
            wrap_d = 1'b1;
          end
        end else begin
          out_d = dec[WIDTH-1:0];
        end
      end
    end
  end

  dff_vec #(.WIDTH(WIDTH)) u_out_q  (.clk(clk), .rst_n(rst), .d(out_d),  .q(out_q));
  dff_vec #(.WIDTH(1))     u_wrap_q (.clk(clk), .rst_n(rst), .d(wrap_d), .q(wrap_q));
  dff_vec #(.WIDTH(1))     u_err_q  (.clk(clk), .rst_n(rst), .d(err_d),  .q(err_q));

  assign out  = out_q;
  assign wrap = wrap_q;
  assign err  = err_q;
  assign tc   = (dir == DIR_UP) ? (cnt_ext == MAX_V) : (cnt_ext == '0);

endmodule

// File: doc/counter_mod.md
Name: counter_mod

Overview:
- Parametrised modulo-N up/down counter; the next generation of the team's 2-bit enable counter.
- Adds:
  - configurable width and modulus
  - count direction
  - synchronous clear and parallel load
  - wrap or saturate mode
  - terminal-count and wrap pulse outputs
  - sticky error flag
- Used as a general sequencing/timeout counter in the datapath and control FSMs.
- State is held in a WIDTH-bit register bank built from the team's flop primitive.

Parameters:
- WIDTH, 4: counter width in bits. Must satisfy 2^WIDTH >= MODULUS; violation is an elaboration error.
- MODULUS, 10: number of states; count range is 0..MODULUS-1. Must be >= 2.
- SATURATE, 0: 0 = wrap at the bounds, 1 = hold at the bounds.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low. The port name follows the codebase; asserted when 0.
- clr  in  1  synchronous clear to 0. Also clears err.
- ld  in  1  synchronous parallel load.
- ld_val  in  WIDTH  load value.
- en  in  1  count enable.
- up  in  1  direction: 1 = increment, 0 = decrement.
- out  out  WIDTH  current count, registered.
- tc  out  1  terminal count (combinational from out and up).
- wrap  out  1  registered one-cycle pulse.
- err  out  1  sticky error flag, registered.

Behaviour:
- Reset (rst=0, asynchronous): out=0, wrap=0, err=0 immediately, independent of clk.
- Priority each cycle: clr > ld > en > hold.
- clr=1:
  - next out=0, err=0, wrap=0.
  - ld and en are ignored.
- ld=1 (clr=0):
  - If ld_val <= MODULUS-1: next out=ld_val, wrap=0.
  - Otherwise the load is rejected: out holds, err sets to 1, wrap=0.
- en=1, up=1 (clr=0, ld=0):
  - out < MODULUS-1: out+1.
  - out = MODULUS-1 and SATURATE=0: out becomes 0 and wrap pulses 1 for the following cycle.
  - out = MODULUS-1 and SATURATE=1: out holds, no wrap pulse.
- en=1, up=0 (clr=0, ld=0):
  - out > 0: out-1.
  - out = 0 and SATURATE=0: out becomes MODULUS-1 and wrap pulses.
  - out = 0 and SATURATE=1: out holds, no wrap pulse.
- en=0 (clr=0, ld=0): out holds, wrap=0.
- tc: 1 when (up=1 and out=MODULUS-1) or (up=0 and out=0). Combinational, zero latency; valid regardless of en.
- wrap: registered, high exactly one cycle after the wrapping edge, 0 otherwise.
- Illegal state (out > MODULUS-1, possible only if WIDTH permits, e.g. after an upset):
  - Next state is 0 when en=1 or on hold; clr/ld priority still applies.
  - err sets to 1.
  - Mirrors the predecessor's default-branch handling.
- err is sticky; only rst or clr clear it.
- All next-state arithmetic is done WIDTH+1 bits wide so there is no silent overflow when MODULUS = 2^WIDTH.
- Latency: a load, clear or count is visible on out one cycle after the sampling edge.
- Reset asserted mid-count: out drops to 0 at once. The first count after rst rises occurs on the first rising edge with en=1.

Decomposition:
- Shared package counter_pkg:
  - localparam helper for clog2
  - enum for direction (DIR_DOWN=0, DIR_UP=1)
  - enum for mode (MODE_WRAP=0, MODE_SAT=1)
- Sub-module dff_vec: WIDTH-bit register bank of the team's flop primitive with asynchronous active-low reset to 0.
  - counter_mod instantiates one dff_vec for out.
  - wrap and err use single-bit flops of the same primitive.
- All next-state logic lives in counter_mod as a single combinational block.

Test Plan (WIDTH=4, MODULUS=10 unless noted):
- Reset then en=1, up=1 for 12 cycles -> out 1,2..9,0,1,2; wrap high in the cycle after 9->0 only; tc=1 while out=9.
- Load and count down: ld=1, ld_val=3, then en=1, up=0 for 5 cycles -> out 3,2,1,0,9,8; wrap pulses once, after 0->9; tc=1 at out=0.
- SATURATE=1, ld_val=8, en=1, up=1 for 4 cycles -> out 9,9,9,9, wrap never 1; then up=0 from out=0 holds at 0.
- Out-of-range load: ld_val=12 while out=5 -> out stays 5, err=1 next cycle and stays 1; clr=1 -> out=0, err=0.
- Priority: clr=1, ld=1, ld_val=7, en=1 same cycle -> out=0. Then ld=1, ld_val=7 with en=1 -> out=7, not 8.
- Asynchronous reset mid-count (out=6) between clock edges -> out=0, err=0, wrap=0 without a clock edge. MODULUS=16, WIDTH=4 run -> 15->0 wrap, no err.
